dm_cache_ctrl: RTL

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

---
 rtl/cache_def.sv | 70 +++++++
 rtl/dm_cache_store.sv | 59 +++++
 rtl/dm_cache_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/cache_def.sv
// rtl/cache_def.sv - shared types and geometry for the direct-mapped cache controller
// Purpose: package cache_def holds every type used by dm_cache_ctrl and dm_cache_store.
//   Geometry: 1024 lines of 128 bits, tag = addr[31:14], index = addr[13:4], word = addr[3:2].
// Ports: none (package). Optional feature macro used by the top: CACHE_STATS_EN.
package cache_def;

  localparam int TAGMSB    = 31;
  localparam int TAGLSB    = 14;
  localparam int INDEX_MSB = 13;
  localparam int INDEX_LSB = 4;
  localparam int NUM_LINES = 1024;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAGMSB:TAGLSB] tag;
  } cache_tag_type;

  typedef struct packed {
    logic [INDEX_MSB-INDEX_LSB:0] index;
    logic                         we;
  } cache_req_type;

  typedef logic [127:0] cache_data_type;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        rw;
    logic        valid;
  } cpu_req_type;

  typedef struct packed {
    logic [31:0] data;
    logic        ready;
  } cpu_result_type;

  typedef struct packed {
    logic [31:0]    addr;
    cache_data_type data;
    logic           rw;
    logic           valid;
  } mem_req_type;

  typedef struct packed {
    cache_data_type data;
    logic           ready;
  } mem_data_type;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    COMPARE_TAG = 2'd1,
    WRITE_BACK  = 2'd2,
    ALLOCATE    = 2'd3
  } cache_state_type;

  // Word 0 occupies bits [31:0] of the line.
  function automatic logic [31:0] get_word(input cache_data_type line, input logic [1:0] w);
    return line[{w, 5'd0} +: 32];
  endfunction

  function automatic cache_data_type put_word(input cache_data_type line, input logic [1:0] w,
                                              input logic [31:0] d);
    cache_data_type r;
    r = line;
    r[{w, 5'd0} +: 32] = d;
    return r;
  endfunction

endpackage

// File: rtl/dm_cache_store.sv
// rtl/dm_cache_store.sv - tag/data arrays with resettable valid and dirty bits
// Purpose: 1024-entry tag and data storage, combinational read and one synchronous write port.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset (clears valid/dirty only)
//   data_req     - index for read and write, we = write enable
//   tag_write    - valid/dirty/tag written when we=1
//   data_write   - 128-bit line written when we=1
//   tag_read     - valid/dirty/tag at data_req.index
//   data_read    - line at data_req.index
module dm_cache_store
  import cache_def::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  cache_req_type  data_req,
  input  cache_tag_type  tag_write,
  input  cache_data_type data_write,
  output cache_tag_type  tag_read,
  output cache_data_type data_read
);

  logic [TAGMSB:TAGLSB] tag_mem  [NUM_LINES];
  cache_data_type       data_mem [NUM_LINES];
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [NUM_LINES-1:0] dirty_q, dirty_d;

  // Tag and data payloads need no reset: a line is only trusted once its valid bit is set.
  always_ff @(posedge clk) begin
    if (data_req.we) begin
      tag_mem[data_req.index]  <= tag_write.tag;
      data_mem[data_req.index] <= data_write;
    end
  end

  always_comb begin
    valid_d = valid_q;
    dirty_d = dirty_q;
    if (data_req.we) begin
      valid_d[data_req.index] = tag_write.valid;
      dirty_d[data_req.index] = tag_write.dirty;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

  assign tag_read.valid = valid_q[data_req.index];
  assign tag_read.dirty = dirty_q[data_req.index];
  assign tag_read.tag   = tag_mem[data_req.index];
  assign data_read      = data_mem[data_req.index];

endmodule

// File: rtl/dm_cache_ctrl.sv
// rtl/dm_cache_ctrl.sv - direct-mapped write-back, write-allocate cache controller
// Purpose: four-state FSM (IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE) in front of dm_cache_store.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   cpu_req     - CPU request (addr, data, rw, valid), sampled only in IDLE
//   cpu_res     - registered CPU response; ready pulses one cycle on a hit
//   mem_req     - registered memory request, held stable while valid
//   mem_data    - memory response (data, ready), honoured in WRITE_BACK/ALLOCATE only
//   hit_count, miss_count - present only when CACHE_STATS_EN is defined
module dm_cache_ctrl
  import cache_def::*;
(
  input  logic           clk,
  input  logic           rst_n,
  input  cpu_req_type    cpu_req,
  output cpu_result_type cpu_res,
  output mem_req_type    mem_req,
  input  mem_data_type   mem_data
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]    hit_count,
  output logic [31:0]    miss_count
`endif
);

  cache_state_type state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            rw_q, rw_d;
  cpu_result_type  cpu_res_q, cpu_res_d;
  mem_req_type     mem_req_q, mem_req_d;

  cache_req_type   data_req;
  cache_tag_type   tag_write, tag_read;
  cache_data_type  data_write, data_read;

  logic [INDEX_MSB-INDEX_LSB:0] index;
  logic [1:0]                   word;
  logic                         hit;
  logic                         unused_addr_bits;

  assign index            = addr_q[INDEX_MSB:INDEX_LSB];
  assign word             = addr_q[3:2];
  assign hit              = tag_read.valid && (tag_read.tag == addr_q[TAGMSB:TAGLSB]);
  assign unused_addr_bits = ^addr_q[1:0];

  dm_cache_store u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .data_req   (data_req),
    .tag_write  (tag_write),
    .data_write (data_write),
    .tag_read   (tag_read),
    .data_read  (data_read)
  );

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    wdata_d         = wdata_q;
    rw_d            = rw_q;
    cpu_res_d       = cpu_res_q;
    cpu_res_d.ready = 1'b0;
    mem_req_d       = mem_req_q;
    data_req.index  = index;
    data_req.we     = 1'b0;
    tag_write       = tag_read;
    data_write      = data_read;

    unique case (state_q)
      IDLE: begin
        if (cpu_req.valid) begin
          addr_d  = cpu_req.addr;
          wdata_d = cpu_req.data;
          rw_d    = cpu_req.rw;
          state_d = COMPARE_TAG;
        end
      end

      COMPARE_TAG: begin
        if (hit) begin
          cpu_res_d.ready = 1'b1;
          state_d         = IDLE;
          if (rw_q) begin
            data_req.we     = 1'b1;
            data_write      = put_word(data_read, word, wdata_q);
            tag_write.valid = 1'b1;
            tag_write.dirty = 1'b1;
            cpu_res_d.data  = wdata_q;
          end else begin
            cpu_res_d.data  = get_word(data_read, word);
          end
        end else if (tag_read.valid && tag_read.dirty) begin
          // The victim line is captured into mem_req here, so later writes cannot disturb it.
          state_d         = WRITE_BACK;
          mem_req_d.addr  = {tag_read.tag, index, 4'b0000};
          mem_req_d.data  = data_read;
          mem_req_d.rw    = 1'b1;
          mem_req_d.valid = 1'b1;
        end else begin
          state_d         = ALLOCATE;
          mem_req_d.addr  = {addr_q[31:4], 4'b0000};
          mem_req_d.rw    = 1'b0;
          mem_req_d.valid = 1'b1;
        end
      end

      WRITE_BACK: begin
        if (mem_data.ready) begin
          state_d         = ALLOCATE;
          mem_req_d.addr  = {addr_q[31:4], 4'b0000};
          mem_req_d.rw    = 1'b0;
          mem_req_d.valid = 1'b1;
        end
      end

      ALLOCATE: begin
        if (mem_data.ready) begin
          // Refill then retry the lookup; the retry hits, which makes write misses allocate.
          data_req.we     = 1'b1;
          data_write      = mem_data.data;
          tag_write.valid = 1'b1;
          tag_write.dirty = 1'b0;
          tag_write.tag   = addr_q[TAGMSB:TAGLSB];
          mem_req_d.valid = 1'b0;
          state_d         = COMPARE_TAG;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rw_q      <= 1'b0;
      cpu_res_q <= '0;
      mem_req_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rw_q      <= rw_d;
      cpu_res_q <= cpu_res_d;
      mem_req_q <= mem_req_d;
    end
  end

  assign cpu_res = cpu_res_q;
  assign mem_req = mem_req_q;

`ifdef CACHE_STATS_EN
  // retry_q marks the COMPARE_TAG pass that follows a refill so it is not counted as a hit.
  logic        retry_q, retry_d;
  logic [31:0] hit_count_q, hit_count_d;
  logic [31:0] miss_count_q, miss_count_d;

  always_comb begin
    retry_d      = retry_q;
    hit_count_d  = hit_count_q;
    miss_count_d = miss_count_q;
    if (state_q == ALLOCATE && mem_data.ready) begin
      retry_d = 1'b1;
    end else if (state_q == COMPARE_TAG) begin
      retry_d = 1'b0;
      if (!hit) begin
        miss_count_d = miss_count_q + 32'd1;
      end else if (!retry_q) begin
        hit_count_d = hit_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q      <= 1'b0;
      hit_count_q  <= '0;
      miss_count_q <= '0;
    end else begin
      retry_q      <= retry_d;
      hit_count_q  <= hit_count_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule
